// File: rtl/lb_pio_pkg.sv
// Shared definitions for the HPS-to-fabric command PIO: register map,
// STATUS bit positions and the command FSM state type.
package lb_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_CMD      = 3'd1;
    localparam logic [2:0] ADDR_STATUS   = 3'd2;
    localparam logic [2:0] ADDR_CMD_DATA = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_OVERRUN = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } cmd_state_e;

endpackage

// File: rtl/lb_cmd_pio_out.sv
// Avalon-MM slave: level output register with set/clear aliases plus a
// one-deep command channel handed to the fabric over valid/ready.
module lb_cmd_pio_out
    import lb_pio_pkg::*;
#(
    parameter int unsigned           DATA_W    = 8,
    parameter logic [DATA_W-1:0]     RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic [DATA_W-1:0] cmd_data,
    output logic              cmd_valid,
    input  logic              cmd_ready
);

    cmd_state_e        state_q, state_d;
    logic [DATA_W-1:0] out_port_q, out_port_d;
    logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic [31:0]       readdata_q, readdata_d;

    logic              wr_en;
    logic              cmd_wr;
    logic [DATA_W-1:0] wdata;
    logic              unused_writedata;

    assign wr_en  = chipselect && !write_n;
    assign cmd_wr = wr_en && (address == ADDR_CMD);
    assign wdata  = writedata[DATA_W-1:0];
    assign unused_writedata = ^writedata;

    // Valid is a pure function of registered state, never of cmd_ready.
    assign cmd_valid = (state_q == PENDING);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d    = state_q;
        out_port_d = out_port_q;
        cmd_data_d = cmd_data_q;
        done_d     = done_q;
        overrun_d  = overrun_q;

        if (wr_en) begin
            case (address)
                ADDR_DATA:   out_port_d = wdata;
                ADDR_OUTSET: out_port_d = out_port_q | wdata;
                ADDR_OUTCLR: out_port_d = out_port_q & ~wdata;
                ADDR_STATUS: begin
                    if (writedata[STAT_DONE])    done_d    = 1'b0;
                    if (writedata[STAT_OVERRUN]) overrun_d = 1'b0;
                end
                default: ;
            endcase
        end

        // Hardware sets come after the W1C clears so a same-cycle set wins.
        case (state_q)
            IDLE: begin
                if (cmd_wr) begin
                    cmd_data_d = wdata;
                    state_d    = PENDING;
                end
            end
            PENDING: begin
                if (cmd_ready) begin
                    done_d = 1'b1;
                    if (cmd_wr) cmd_data_d = wdata;
                    else        state_d    = IDLE;
                end else if (cmd_wr) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        readdata_d = '0;
        case (address)
            ADDR_DATA:     readdata_d = 32'(out_port_q);
            ADDR_STATUS: begin
                readdata_d[STAT_BUSY]    = (state_q == PENDING);
                readdata_d[STAT_DONE]    = done_q;
                readdata_d[STAT_OVERRUN] = overrun_q;
            end
            ADDR_CMD_DATA: readdata_d = 32'(cmd_data_q);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            state_q    <= IDLE;
            out_port_q <= RESET_VAL;
            cmd_data_q <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            out_port_q <= out_port_d;
            cmd_data_q <= cmd_data_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            readdata_q <= readdata_d;
        end
    end

    assign out_port = out_port_q;
    assign cmd_data = cmd_data_q;
    assign readdata = readdata_q;

endmodule

// File: tb/tb_lb_cmd_pio_out.sv
// Directed bench for lb_cmd_pio_out: output register aliases, command
// handshake, sticky flags and reset behaviour, with hand-computed values.
module tb_lb_cmd_pio_out;

    localparam int unsigned   DATA_W    = 8;
    localparam logic [7:0]    RESET_VAL = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;

    int n_checks = 0;
    int n_fail   = 0;

    lb_cmd_pio_out #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    logic [31:0] rd;

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        cmd_ready  = 1'b0;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_port",  32'(out_port),  32'h0000_00A5);
        check("rst_cmd_valid", 32'(cmd_valid), 32'h0);
        check("rst_cmd_data",  32'(cmd_data),  32'h0);
        check("rst_readdata",  readdata,       32'h0);
        reset_n = 1'b1;
        bus_read(3'd2, rd);
        check("rst_status", rd, 32'h0);

        // DATA / OUTSET / OUTCLEAR, upper writedata bits ignored
        bus_write(3'd0, 32'hFFFF_FF3C);
        check("data_wr", 32'(out_port), 32'h3C);
        bus_write(3'd4, 32'hFFFF_FF81);
        check("outset", 32'(out_port), 32'hBD);
        bus_write(3'd5, 32'hFFFF_FF0C);
        check("outclr", 32'(out_port), 32'hB1);
        bus_read(3'd0, rd);
        check("data_rd", rd, 32'h0000_00B1);

        // Read in the write cycle returns the old value
        bus_write(3'd0, 32'h0000_0055);
        check("rd_old_val",  readdata,       32'h0000_00B1);
        check("data_wr_new", 32'(out_port),  32'h55);
        bus_write(3'd7, 32'hFFFF_FFFF);
        check("addr7_ignored", 32'(out_port), 32'h55);
        bus_read(3'd7, rd);
        check("addr7_rd", rd, 32'h0);
        bus_read(3'd1, rd);
        check("cmd_rd_zero", rd, 32'h0);

        // Command with fabric delay
        bus_write(3'd1, 32'hFFFF_FF42);
        check("cmd_valid_set", 32'(cmd_valid), 32'h1);
        check("cmd_data_42",   32'(cmd_data),  32'h42);
        bus_read(3'd3, rd);
        check("cmd_data_rd", rd, 32'h42);
        bus_read(3'd2, rd);
        check("status_busy", rd, 32'h1);
        repeat (5) @(negedge clk);
        check("cmd_held_valid", 32'(cmd_valid), 32'h1);
        check("cmd_held_data",  32'(cmd_data),  32'h42);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("cmd_accepted", 32'(cmd_valid), 32'h0);
        bus_read(3'd2, rd);
        check("status_done", rd, 32'h2);
        bus_write(3'd2, 32'h2);
        bus_read(3'd2, rd);
        check("status_done_clr", rd, 32'h0);

        // Overrun
        bus_write(3'd1, 32'h11);
        bus_write(3'd1, 32'h22);
        check("ovr_data_kept", 32'(cmd_data), 32'h11);
        bus_read(3'd2, rd);
        check("status_ovr", rd, 32'h5);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        bus_read(3'd2, rd);
        check("status_ovr_done", rd, 32'h6);
        bus_write(3'd2, 32'h6);
        bus_read(3'd2, rd);
        check("status_ovr_clr", rd, 32'h0);

        // Back-to-back: accept old and load new on the same edge
        bus_write(3'd1, 32'h11);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd1;
        writedata  = 32'h22;
        cmd_ready  = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        cmd_ready  = 1'b0;
        check("b2b_valid", 32'(cmd_valid), 32'h1);
        check("b2b_data",  32'(cmd_data),  32'h22);
        bus_read(3'd2, rd);
        check("b2b_status", rd, 32'h3);

        // Hardware set beats a same-cycle W1C of done
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd2;
        writedata  = 32'h2;
        cmd_ready  = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        cmd_ready  = 1'b0;
        check("set_wins_valid", 32'(cmd_valid), 32'h0);
        bus_read(3'd2, rd);
        check("set_wins_status", rd, 32'h2);

        // Reset mid-PENDING with done set
        bus_write(3'd1, 32'h33);
        check("pre_rst_valid", 32'(cmd_valid), 32'h1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midrst_valid",    32'(cmd_valid), 32'h0);
        check("midrst_data",     32'(cmd_data),  32'h0);
        check("midrst_out_port", 32'(out_port),  32'hA5);
        check("midrst_readdata", readdata,       32'h0);
        cmd_ready = 1'b1;
        repeat (3) @(negedge clk);
        cmd_ready = 1'b0;
        check("idle_ready_valid", 32'(cmd_valid), 32'h0);
        bus_read(3'd2, rd);
        check("idle_ready_status", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
